// File: rtl/ast_alert_ctrl.sv
// ast_alert_ctrl: four-phase differential alert handshake for NumAlerts senders through a single
// round-robin engine, with per-channel integrity checking and sticky error flags.
// Optional feature macro: AST_ALERT_CTRL_PING_EN compiles in the periodic liveness-ping scheduler.
module ast_alert_ctrl #(
  parameter int unsigned NumAlerts  = 2,
  parameter int unsigned PingPeriod = 1024,
  parameter int unsigned Timeout    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [NumAlerts-1:0] alert_p_i,
  input  logic [NumAlerts-1:0] alert_n_i,
  output logic [NumAlerts-1:0] ack_p_o,
  output logic [NumAlerts-1:0] ack_n_o,
  output logic [NumAlerts-1:0] ping_p_o,
  output logic [NumAlerts-1:0] ping_n_o,
  output logic [NumAlerts-1:0] alert_evt_o,
  output logic [NumAlerts-1:0] integ_err_o,
  output logic [NumAlerts-1:0] ping_fail_o,
  output logic                 busy_o
);

  localparam int unsigned     IdxW    = (NumAlerts > 1) ? $clog2(NumAlerts) : 1;
  localparam int unsigned     TmoW    = $clog2(Timeout);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumAlerts - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(Timeout - 1);

  if (NumAlerts < 1 || PingPeriod < 2 || Timeout < 2) begin : g_param_check
    $error("ast_alert_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StAck, StRel} state_e;

  state_e               r_state, w_state_d;
  logic [IdxW-1:0]      r_ptr, w_ptr_d;      // last granted channel
  logic [IdxW-1:0]      r_idx, w_idx_d;      // channel owning the handshake
  logic [TmoW-1:0]      r_tmo, w_tmo_d;
  logic [NumAlerts-1:0] r_ack_p, w_ack_p_d, r_ack_n, w_ack_n_d;
  logic [NumAlerts-1:0] r_evt, w_evt_d, r_integ, w_integ_d, w_hs_err;
  logic                 r_busy;

  logic [NumAlerts-1:0] w_req, w_bad, w_gnt_oh, w_ping_p;
  logic [IdxW-1:0]      w_gnt_idx, w_cand;
  logic                 w_gnt_vld, w_grant, w_ping_hit;

  assign w_req      = alert_p_i & ~alert_n_i;
  assign w_bad      = ~(alert_p_i ^ alert_n_i);
  assign w_ping_hit = w_ping_p[w_gnt_idx];

  // Round-robin pick: first asserted channel after the last granted one.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned i = 1; i <= NumAlerts; i++) begin
      w_cand = IdxW'((32'(r_ptr) + i) % NumAlerts);
      if (!w_gnt_vld && w_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_gnt_oh            = '0;
    w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  // Handshake next-state, ack drive, event pulse and integrity flag update.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_idx_d   = r_idx;
    w_tmo_d   = r_tmo;
    w_ack_p_d = r_ack_p;
    w_ack_n_d = r_ack_n;
    w_evt_d   = '0;
    w_hs_err  = '0;
    w_grant   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (en_i && w_gnt_vld) begin
          w_state_d = StAck;
          w_ptr_d   = w_gnt_idx;
          w_idx_d   = w_gnt_idx;
          w_tmo_d   = '0;
          w_grant   = 1'b1;
          w_ack_p_d = w_gnt_oh;
          w_ack_n_d = ~w_gnt_oh;
          // A grant that answers an outstanding ping is not a genuine alert.
          if (!w_ping_hit) w_evt_d = w_gnt_oh;
        end
      end
      StAck: begin
        if (w_bad[r_idx] || !w_req[r_idx] || r_tmo == TmoLast) begin
          w_state_d = StRel;
          w_ack_p_d = '0;
          w_ack_n_d = '1;
          if (w_req[r_idx] || w_bad[r_idx]) w_hs_err[r_idx] = 1'b1;
        end else begin
          w_tmo_d = r_tmo + 1'b1;
        end
      end
      StRel: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Set wins over clear.
    w_integ_d = (clr_i ? '0 : r_integ) | w_bad | w_hs_err;
  end

  // Handshake state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ptr   <= LastIdx;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_ack_p <= '0;
      r_ack_n <= '1;
      r_evt   <= '0;
      r_integ <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_idx   <= w_idx_d;
      r_tmo   <= w_tmo_d;
      r_ack_p <= w_ack_p_d;
      r_ack_n <= w_ack_n_d;
      r_evt   <= w_evt_d;
      r_integ <= w_integ_d;
      r_busy  <= (w_state_d != StIdle);
    end
  end

  assign ack_p_o     = r_ack_p;
  assign ack_n_o     = r_ack_n;
  assign alert_evt_o = r_evt;
  assign integ_err_o = r_integ;
  assign busy_o      = r_busy;

`ifdef AST_ALERT_CTRL_PING_EN
  localparam int unsigned     PerW    = $clog2(PingPeriod);
  localparam logic [PerW-1:0] PerLast = PerW'(PingPeriod - 1);

  logic [PerW-1:0]      r_pcnt, w_pcnt_d;
  logic [IdxW-1:0]      r_pptr, w_pptr_d;
  logic [TmoW-1:0]      r_ptmo, w_ptmo_d;
  logic [NumAlerts-1:0] r_ping_p, r_ping_n, w_ping_p_d, r_pfail, w_pfail_set, w_pptr_oh;
  logic                 w_pact_d;

  assign w_ping_p = r_ping_p;

  // Ping scheduler: count, issue, wait for grant or timeout, then move to the next channel.
  always_comb begin
    w_pcnt_d              = r_pcnt;
    w_pptr_d              = r_pptr;
    w_ptmo_d              = r_ptmo;
    w_pact_d              = |r_ping_p;
    w_pfail_set           = '0;
    w_pptr_oh             = '0;
    w_pptr_oh[r_pptr]     = 1'b1;
    if (!en_i) begin
      w_pcnt_d = '0;
      w_pact_d = 1'b0;
    end else if (|r_ping_p) begin
      if (w_grant && w_ping_hit) begin
        w_pact_d = 1'b0;
        w_pptr_d = (r_pptr == LastIdx) ? '0 : r_pptr + 1'b1;
      end else if (r_ptmo == TmoLast) begin
        w_pfail_set = w_pptr_oh;
        w_pact_d    = 1'b0;
        w_pptr_d    = (r_pptr == LastIdx) ? '0 : r_pptr + 1'b1;
      end else begin
        w_ptmo_d = r_ptmo + 1'b1;
      end
    end else if (r_pcnt == PerLast) begin
      w_pact_d = 1'b1;
      w_ptmo_d = '0;
      w_pcnt_d = '0;
    end else begin
      w_pcnt_d = r_pcnt + 1'b1;
    end
    // The pointer only moves when the ping drops, so it is stable while one is active.
    w_ping_p_d = w_pact_d ? w_pptr_oh : '0;
  end

  // Ping scheduler state and registered ping outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pcnt   <= '0;
      r_pptr   <= '0;
      r_ptmo   <= '0;
      r_ping_p <= '0;
      r_ping_n <= '1;
      r_pfail  <= '0;
    end else begin
      r_pcnt   <= w_pcnt_d;
      r_pptr   <= w_pptr_d;
      r_ptmo   <= w_ptmo_d;
      r_ping_p <= w_ping_p_d;
      r_ping_n <= ~w_ping_p_d;
      r_pfail  <= (clr_i ? '0 : r_pfail) | w_pfail_set;
    end
  end

  assign ping_p_o    = r_ping_p;
  assign ping_n_o    = r_ping_n;
  assign ping_fail_o = r_pfail;
`else
  assign w_ping_p    = '0;
  assign ping_p_o    = '0;
  assign ping_n_o    = '1;
  assign ping_fail_o = '0;
`endif

endmodule

// File: tb/tb_ast_alert_ctrl.sv
// tb_ast_alert_ctrl: directed and randomized checks of ast_alert_ctrl against a behavioural
// model of the handshake, integrity and ping rules.
module tb_ast_alert_ctrl;
  localparam int N = 2;
  localparam int P = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst, en, clr;
  logic [N-1:0] a_p, a_n;
  logic [N-1:0] ack_p_o, ack_n_o, ping_p_o, ping_n_o, alert_evt_o, integ_err_o, ping_fail_o;
  logic         busy_o;
  wire  [7*N:0] obs = {ack_p_o, ack_n_o, ping_p_o, ping_n_o, alert_evt_o, integ_err_o,
                       ping_fail_o, busy_o};
  localparam logic [7*N:0] RstVec = {2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  // Model: channel currently acknowledged (-1 none), cycles it has been shown, release slot.
  int       m_ch, m_age, m_last;
  bit       m_rel;
  bit [N-1:0] m_evt, m_integ, m_fail;
  bit       m_pon;
  int       m_pch, m_page, m_pcnt;

  ast_alert_ctrl #(.NumAlerts(N), .PingPeriod(P), .Timeout(T)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .alert_p_i(a_p), .alert_n_i(a_n),
    .ack_p_o(ack_p_o), .ack_n_o(ack_n_o), .ping_p_o(ping_p_o), .ping_n_o(ping_n_o),
    .alert_evt_o(alert_evt_o), .integ_err_o(integ_err_o), .ping_fail_o(ping_fail_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic model_reset();
    m_ch = -1; m_age = 0; m_last = N - 1; m_rel = 0;
    m_evt = '0; m_integ = '0; m_fail = '0;
    m_pon = 0; m_pch = 0; m_page = 0; m_pcnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    logic [N-1:0] req, bad, seti, setf;
    bit hit;
    req = a_p & ~a_n;
    bad = ~(a_p ^ a_n);
    seti = bad; setf = '0; hit = 0; m_evt = '0;
    if (m_rel) begin
      m_rel = 0;
    end else if (m_ch >= 0) begin
      if (!a_p[m_ch] && a_n[m_ch]) begin
        m_ch = -1; m_rel = 1;
      end else if (bad[m_ch]) begin
        m_ch = -1; m_rel = 1;
      end else if (m_age == T - 1) begin
        seti[m_ch] = 1'b1; m_ch = -1; m_rel = 1;
      end else begin
        m_age++;
      end
    end else if (en) begin
      for (int i = 1; i <= N && m_ch < 0; i++) begin
        int c = (m_last + i) % N;
        if (req[c]) begin
          m_ch = c; m_last = c; m_age = 0;
          if (m_pon && m_pch == c) hit = 1;
          else m_evt[c] = 1'b1;
        end
      end
    end
`ifdef AST_ALERT_CTRL_PING_EN
    if (!en) begin
      m_pon = 0; m_pcnt = 0;
    end else if (m_pon) begin
      if (hit) begin
        m_pon = 0; m_pch = (m_pch + 1) % N;
      end else if (m_page == T - 1) begin
        setf[m_pch] = 1'b1; m_pon = 0; m_pch = (m_pch + 1) % N;
      end else begin
        m_page++;
      end
    end else if (m_pcnt == P - 1) begin
      m_pon = 1; m_page = 0; m_pcnt = 0;
    end else begin
      m_pcnt++;
    end
`endif
    m_integ = (clr ? '0 : m_integ) | seti;
    m_fail  = (clr ? '0 : m_fail) | setf;
  endtask

  function automatic logic [7*N:0] exp_vec();
    logic [N-1:0] ack, png;
    ack = '0; png = '0;
    if (m_ch >= 0) ack[m_ch] = 1'b1;
    if (m_pon) png[m_pch] = 1'b1;
    return {ack, ~ack, png, ~png, m_evt, m_integ, m_fail, (m_ch >= 0) || m_rel};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // mode: 0 idle, 1 asserted, 2 p=n=1, 3 p=n=0
  task automatic set_ch(input int k, input int mode);
    case (mode)
      0: begin a_p[k] = 1'b0; a_n[k] = 1'b1; end
      1: begin a_p[k] = 1'b1; a_n[k] = 1'b0; end
      2: begin a_p[k] = 1'b1; a_n[k] = 1'b1; end
      default: begin a_p[k] = 1'b0; a_n[k] = 1'b0; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; a_p = '0; a_n = '1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; a_p = '0; a_n = '1;
    #1;
    n_vec++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL reset_vals got=%h want=%h", obs, RstVec);
    end
    en = 1'b1; set_ch(0, 1); set_ch(1, 2);
    @(posedge clk);
    #1;
    n_vec++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL reset_hold got=%h want=%h", obs, RstVec);
    end
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 6) set_ch(0, 1);
      if (c == 10) set_ch(0, 0);
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL basic_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 6) begin
        n_vec++;
        if (ack_p_o !== 2'b01 || alert_evt_o !== 2'b01 || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL basic_assert ack=%b evt=%b busy=%b want 01 01 1", ack_p_o,
                   alert_evt_o, busy_o);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (alert_evt_o !== 2'b00 || ack_p_o !== 2'b01) begin
          n_err++; $display("FAIL basic_pulse evt=%b ack=%b want 00 01", alert_evt_o, ack_p_o);
        end
      end
      if (c == 10) begin
        n_vec++;
        if (ack_p_o !== 2'b00 || ack_n_o !== 2'b11 || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL basic_release ack_p=%b ack_n=%b busy=%b want 00 11 1", ack_p_o,
                   ack_n_o, busy_o);
        end
      end
      if (c == 11) begin
        n_vec++;
        if (busy_o !== 1'b0) begin
          n_err++; $display("FAIL basic_idle busy=%b want 0", busy_o);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_ord[5] = '{0, 1, 0, 1, 0};
    logic [N-1:0] prev;
    do_reset();
    en = 1'b1;
    set_ch(0, 1); set_ch(1, 1);
    prev = '0;
    for (int c = 1; c <= 80 && order.size() < 5; c++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL rr_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      for (int k = 0; k < N; k++) begin
        if (ack_p_o[k] && !prev[k]) begin
          order.push_back(k);
          set_ch(k, 0);
        end
      end
      prev = ack_p_o;
      if (!busy_o && a_p == '0) begin
        if (order.size() == 2) set_ch(0, 1);
        else if (order.size() == 3) begin set_ch(0, 1); set_ch(1, 1); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= order.size() || order[i] != exp_ord[i]) begin
        n_err++;
        $display("FAIL rr_order idx=%0d got=%0d want=%0d", i,
                 (i < order.size()) ? order[i] : -1, exp_ord[i]);
      end
    end
  endtask

  task automatic test_integrity();
    do_reset();
    en = 1'b1;
    tick();
    set_ch(1, 2);
    tick();
    n_vec++;
    if (integ_err_o !== 2'b10 || ack_p_o !== 2'b00) begin
      n_err++; $display("FAIL integ_set integ=%b ack=%b want 10 00", integ_err_o, ack_p_o);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (integ_err_o !== 2'b10) begin
      n_err++; $display("FAIL integ_set_wins integ=%b want 10", integ_err_o);
    end
    set_ch(1, 3);
    tick();
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL integ_vec got=%h want=%h", obs, exp_vec());
    end
    set_ch(1, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (integ_err_o !== 2'b00 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL integ_clear integ=%b busy=%b want 00 0", integ_err_o, busy_o);
    end
  endtask

  task automatic test_ack_timeout();
    int  acks;
    bit  done;
    do_reset();
    en = 1'b1;
    set_ch(0, 1);
    acks = 0; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL tmo_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (ack_p_o[0]) acks++;
      if (integ_err_o[0]) done = 1;
    end
    n_vec++;
    if (!done || acks != T || ack_p_o !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_flag seen=%0d ack_cycles=%0d ack=%b want 1 %0d 00", done, acks,
               ack_p_o, T);
    end
    set_ch(0, 0);
    tick();
    n_vec++;
    if (busy_o !== 1'b0 || ack_n_o !== 2'b11) begin
      n_err++; $display("FAIL tmo_idle busy=%b ack_n=%b want 0 11", busy_o, ack_n_o);
    end
  endtask

`ifdef AST_ALERT_CTRL_PING_EN
  task automatic test_ping();
    logic [N-1:0] evt_seen;
    do_reset();
    en = 1'b1;
    evt_seen = '0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL ping_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      evt_seen |= alert_evt_o;
      if (c == 7 || c == 8 || c == 32 || c == 34 || c == 45) begin
        n_vec++;
        if (ping_p_o !== ((c == 8) ? 2'b01 : (c == 32) ? 2'b10 : 2'b00)) begin
          n_err++; $display("FAIL ping_issue cyc=%0d ping_p=%b", c, ping_p_o);
        end
      end
      if (c == 23 || c == 24 || c == 50) begin
        n_vec++;
        if (ping_fail_o !== ((c == 23) ? 2'b00 : 2'b01)) begin
          n_err++; $display("FAIL ping_fail cyc=%0d fail=%b", c, ping_fail_o);
        end
      end
      if (c == 33) set_ch(1, 1);
      if (c >= 34 && ack_p_o[1]) set_ch(1, 0);
      if (c == 44) en = 1'b0;
    end
    n_vec++;
    if (evt_seen !== 2'b00) begin
      n_err++; $display("FAIL ping_no_event evt=%b want 00", evt_seen);
    end
  endtask
`else
  task automatic test_ping_off();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 9) set_ch(0, 1);
      if (c == 12) set_ch(0, 0);
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL noping_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 9 || c == 20 || c == 40) begin
        n_vec++;
        if (ping_p_o !== 2'b00 || ping_n_o !== 2'b11 || ping_fail_o !== 2'b00 ||
            alert_evt_o !== ((c == 9) ? 2'b01 : 2'b00)) begin
          n_err++;
          $display("FAIL noping_tie cyc=%0d ping_p=%b ping_n=%b fail=%b evt=%b", c, ping_p_o,
                   ping_n_o, ping_fail_o, alert_evt_o);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    set_ch(1, 2);
    tick();
    set_ch(1, 0); set_ch(0, 1);
    tick();
    tick();
    n_vec++;
    if (ack_p_o !== 2'b01 || integ_err_o !== 2'b10) begin
      n_err++; $display("FAIL arst_pre ack=%b integ=%b want 01 10", ack_p_o, integ_err_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL arst_immediate got=%h want=%h", obs, RstVec);
    end
    model_reset();
    set_ch(0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL arst_no_event got=%h want=%h", obs, RstVec);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          int r = $urandom_range(0, 19);
          set_ch(k, (r < 9) ? 0 : (r < 18) ? 1 : (r < 19) ? 2 : 3);
        end
      end
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL rand_vec cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_integrity();
    test_ack_timeout();
`ifdef AST_ALERT_CTRL_PING_EN
    test_ping();
`else
    test_ping_off();
`endif
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
